// File: rtl/axil_mem_arbiter_if.sv
// AXI-lite bus bundle between the memory arbiter and the shared RAM slave.
// The master modport is the arbiter side, the slave modport is the RAM side.
interface axil_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rvalid;
    logic                    rready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output araddr, arvalid, input arready,
        input  rdata, rvalid, output rready,
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bvalid, output bready
    );

    modport slave (
        input  araddr, arvalid, output arready,
        output rdata, rvalid, input rready,
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bvalid, input bready
    );
endinterface

// File: rtl/axil_mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single AXI-lite RAM slave.
// One transaction in flight at a time; the granted request is latched and
// its completion is reported with a one-cycle Done pulse on the owner port.
// Build option ARB_DATA_PRIORITY_EN: data port always wins a tie (fixed
// priority). Without it, ties alternate using the last granted port.
//
// state           | meaning
// ----------------+-----------------------------------------------
// IDLE            | sample requests, grant and latch the winner
// READ_ADDR       | arvalid with latched address, wait for arready
// READ_DATA       | rready, capture rdata into owner's output
// WRITE_ADDR_DATA | aw/w channels, each drops after its handshake
// WRITE_RESP      | bready, wait for bvalid
// DONE            | owner's Done pulses for one cycle
module axil_mem_arbiter #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                i_Clock,
    input  logic                i_Reset,
    input  logic                i_Fetch_Req,
    input  logic [XLEN-1:0]     i_Fetch_Addr,
    output logic [XLEN-1:0]     o_Fetch_Data,
    output logic                o_Fetch_Done,
    input  logic                i_Data_Req,
    input  logic                i_Data_Write_Enable,
    input  logic [XLEN-1:0]     i_Data_Addr,
    input  logic [XLEN-1:0]     i_Data_Wdata,
    input  logic [XLEN/8-1:0]   i_Data_Strb,
    output logic [XLEN-1:0]     o_Data_Rdata,
    output logic                o_Data_Done,
    axil_mem_arbiter_if.master  axil
);

    typedef enum logic [2:0] {
        IDLE, READ_ADDR, READ_DATA, WRITE_ADDR_DATA, WRITE_RESP, DONE
    } state_t;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DATA  = 1'b1
    } port_t;

    state_t                r_State;
    state_t                w_Next_State;
    port_t                 r_Owner;
    port_t                 w_Grant;
    logic                  w_Grant_Valid;
    logic [ADDR_WIDTH-1:0] r_Addr;
    logic [XLEN-1:0]       r_Wdata;
    logic [XLEN/8-1:0]     r_Strb;
    logic                  r_Aw_Done;
    logic                  r_W_Done;
`ifndef ARB_DATA_PRIORITY_EN
    port_t                 r_Last_Grant;
`endif

    // Address bits above the AXI-lite window are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_Fetch_Addr[XLEN-1:ADDR_WIDTH], i_Data_Addr[XLEN-1:ADDR_WIDTH]};

    assign axil.araddr = r_Addr;
    assign axil.awaddr = r_Addr;
    assign axil.wdata  = r_Wdata;
    assign axil.wstrb  = r_Strb;

    // Arbitration: single request wins outright, a tie goes by policy.
    always_comb begin
        w_Grant_Valid = i_Fetch_Req | i_Data_Req;
        w_Grant       = PORT_FETCH;
        if (i_Fetch_Req && i_Data_Req) begin
`ifdef ARB_DATA_PRIORITY_EN
            w_Grant = PORT_DATA;
`else
            w_Grant = (r_Last_Grant == PORT_FETCH) ? PORT_DATA : PORT_FETCH;
`endif
        end else if (i_Data_Req) begin
            w_Grant = PORT_DATA;
        end
    end

    // State register.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) r_State <= IDLE;
        else         r_State <= w_Next_State;
    end

    // Next-state and handshake/Done outputs.
    always_comb begin
        w_Next_State = r_State;
        axil.arvalid = 1'b0;
        axil.rready  = 1'b0;
        axil.awvalid = 1'b0;
        axil.wvalid  = 1'b0;
        axil.bready  = 1'b0;
        o_Fetch_Done = 1'b0;
        o_Data_Done  = 1'b0;
        case (r_State)
            IDLE: begin
                if (w_Grant_Valid)
                    w_Next_State = (w_Grant == PORT_DATA && i_Data_Write_Enable) ? WRITE_ADDR_DATA : READ_ADDR;
            end
            READ_ADDR: begin
                axil.arvalid = 1'b1;
                if (axil.arready) w_Next_State = READ_DATA;
            end
            READ_DATA: begin
                axil.rready = 1'b1;
                if (axil.rvalid) w_Next_State = DONE;
            end
            WRITE_ADDR_DATA: begin
                axil.awvalid = !r_Aw_Done;
                axil.wvalid  = !r_W_Done;
                if ((r_Aw_Done || axil.awready) && (r_W_Done || axil.wready))
                    w_Next_State = WRITE_RESP;
            end
            WRITE_RESP: begin
                axil.bready = 1'b1;
                if (axil.bvalid) w_Next_State = DONE;
            end
            DONE: begin
                o_Fetch_Done = (r_Owner == PORT_FETCH);
                o_Data_Done  = (r_Owner == PORT_DATA);
                w_Next_State = IDLE;
            end
            default: w_Next_State = IDLE;
        endcase
    end

    // Request latch, per-channel write acceptance and read-data capture.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_Owner      <= PORT_FETCH;
            r_Addr       <= '0;
            r_Wdata      <= '0;
            r_Strb       <= '0;
            r_Aw_Done    <= 1'b0;
            r_W_Done     <= 1'b0;
            o_Fetch_Data <= '0;
            o_Data_Rdata <= '0;
`ifndef ARB_DATA_PRIORITY_EN
            r_Last_Grant <= PORT_FETCH;
`endif
        end else begin
            if (r_State == IDLE && w_Grant_Valid) begin
                r_Owner   <= w_Grant;
                r_Aw_Done <= 1'b0;
                r_W_Done  <= 1'b0;
`ifndef ARB_DATA_PRIORITY_EN
                r_Last_Grant <= w_Grant;
`endif
                if (w_Grant == PORT_DATA) begin
                    r_Addr  <= i_Data_Addr[ADDR_WIDTH-1:0];
                    r_Wdata <= i_Data_Wdata;
                    r_Strb  <= i_Data_Strb;
                end else begin
                    r_Addr  <= i_Fetch_Addr[ADDR_WIDTH-1:0];
                    r_Strb  <= '0;
                end
            end
            if (r_State == WRITE_ADDR_DATA) begin
                if (axil.awvalid && axil.awready) r_Aw_Done <= 1'b1;
                if (axil.wvalid && axil.wready)   r_W_Done  <= 1'b1;
            end
            if (r_State == READ_DATA && axil.rvalid) begin
                if (r_Owner == PORT_DATA) o_Data_Rdata <= axil.rdata;
                else                      o_Fetch_Data <= axil.rdata;
            end
        end
    end

endmodule

// File: tb/tb_axil_mem_arbiter.sv
// Bench for axil_mem_arbiter: behavioural AXI-lite RAM slave with settable
// or random ready latencies, directed vectors, corner sequences and a
// randomized run checked against a transaction-level arbitration model.
`timescale 1ns/1ps
module tb_axil_mem_arbiter;

    localparam int XLEN = 32;
    localparam int AW   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req;
    logic [31:0] f_addr;
    logic [31:0] f_data;
    logic        f_done;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_strb;
    logic [31:0] d_rdata;
    logic        d_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axil_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(XLEN)) bus ();

    axil_mem_arbiter #(.XLEN(XLEN), .ADDR_WIDTH(AW)) dut (
        .i_Clock             (clk),
        .i_Reset             (rst),
        .i_Fetch_Req         (f_req),
        .i_Fetch_Addr        (f_addr),
        .o_Fetch_Data        (f_data),
        .o_Fetch_Done        (f_done),
        .i_Data_Req          (d_req),
        .i_Data_Write_Enable (d_we),
        .i_Data_Addr         (d_addr),
        .i_Data_Wdata        (d_wdata),
        .i_Data_Strb         (d_strb),
        .o_Data_Rdata        (d_rdata),
        .o_Data_Done         (d_done),
        .axil                (bus)
    );

    function automatic logic [31:0] init_word(int i);
        return (i == 4) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i) * 32'h0001_0203;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // ---------------- behavioural AXI-lite RAM slave ----------------
    logic [31:0] mem [0:255];
    bit          mem_loaded = 0;
    int          cfg_ar_lat = 0, cfg_aw_lat = 0, cfg_w_lat = 0;
    bit          rand_lat = 0;
    int          rnd_ar, rnd_aw, rnd_w;
    int          ar_cnt, aw_cnt, w_cnt;
    int          ar_lat_e, aw_lat_e, w_lat_e;
    logic        aw_got, w_got, s_rvalid, s_bvalid;
    logic [15:0] s_awaddr;
    logic [31:0] s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        aw_hs, w_hs, aw_have, w_have;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;

    always_comb begin
        ar_lat_e = rand_lat ? rnd_ar : cfg_ar_lat;
        aw_lat_e = rand_lat ? rnd_aw : cfg_aw_lat;
        w_lat_e  = rand_lat ? rnd_w  : cfg_w_lat;
    end

    assign bus.arready = bus.arvalid && (ar_cnt >= ar_lat_e);
    assign bus.awready = bus.awvalid && (aw_cnt >= aw_lat_e);
    assign bus.wready  = bus.wvalid  && (w_cnt  >= w_lat_e);
    assign bus.rvalid  = s_rvalid;
    assign bus.rdata   = s_rdata;
    assign bus.bvalid  = s_bvalid;
    assign aw_hs   = bus.awvalid && bus.awready;
    assign w_hs    = bus.wvalid && bus.wready;
    assign aw_have = aw_got || aw_hs;
    assign w_have  = w_got || w_hs;
    assign wr_addr = aw_got ? s_awaddr : bus.awaddr;
    assign wr_data = w_got ? s_wdata : bus.wdata;
    assign wr_strb = w_got ? s_wstrb : bus.wstrb;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            mem_loaded <= 1;
        end
        if (rst) begin
            ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0;
            rnd_ar <= 0; rnd_aw <= 0; rnd_w <= 0;
            aw_got <= 0; w_got <= 0; s_rvalid <= 0; s_bvalid <= 0;
            s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0; s_rdata <= '0;
        end else begin
            if (bus.arvalid && !bus.arready) ar_cnt <= ar_cnt + 1;
            if (bus.arvalid && bus.arready) begin
                ar_cnt   <= 0;
                s_rvalid <= 1;
                s_rdata  <= mem[bus.araddr[9:2]];
                rnd_ar   <= $urandom_range(0, 3);
            end
            if (s_rvalid && bus.rready) s_rvalid <= 0;
            if (bus.awvalid && !bus.awready) aw_cnt <= aw_cnt + 1;
            if (aw_hs) begin aw_cnt <= 0; aw_got <= 1; s_awaddr <= bus.awaddr; rnd_aw <= $urandom_range(0, 3); end
            if (bus.wvalid && !bus.wready) w_cnt <= w_cnt + 1;
            if (w_hs) begin w_cnt <= 0; w_got <= 1; s_wdata <= bus.wdata; s_wstrb <= bus.wstrb; rnd_w <= $urandom_range(0, 3); end
            if (aw_have && w_have && !s_bvalid) begin
                mem[wr_addr[9:2]] <= merge(mem[wr_addr[9:2]], wr_data, wr_strb);
                s_bvalid <= 1;
                aw_got   <= 0;
                w_got    <= 0;
            end
            if (s_bvalid && bus.bready) s_bvalid <= 0;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one request at the current negedge and wait for any Done.
    task automatic run_txn(input bit is_d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, output int lat, output logic [1:0] dn, output logic [31:0] data);
        if (is_d) begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata; d_strb = strb; end
        else begin f_req = 1; f_addr = addr; end
        lat = -1; dn = 2'b00; data = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (f_done || d_done) begin
                lat = k; dn = {f_done, d_done}; data = is_d ? d_rdata : f_data;
                break;
            end
        end
        f_req = 0; d_req = 0;
    endtask

    task automatic do_reset();
        rst = 1; f_req = 0; d_req = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t        vecs [7];
    logic [31:0] ref_mem [0:255];

    // random-run model state
    bit          m_busy, m_owner, done_prev;
`ifndef ARB_DATA_PRIORITY_EN
    bit          m_last;
`endif
    bit          m_d_we;
    logic [31:0] m_d_addr, m_d_wdata, exp_f, exp_d, last_f, last_d;
    logic [3:0]  m_d_strb;
    int          busy_cyc, txn_done;

    initial begin
        int          lat;
        logic [1:0]  dn;
        logic [31:0] data;
        logic [1:0]  exp_dn;
        bit          win;

        rst = 1; f_req = 0; f_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_strb = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

        vecs[0] = '{0, 0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEADBEEF, 3};
        vecs[1] = '{1, 0, 32'h0000_0020, 32'h0,         4'h0, 32'h12345678, 3};
        vecs[2] = '{1, 1, 32'h0000_0020, 32'hAABBCCDD, 4'h5, 32'h0,        3};
        vecs[3] = '{1, 0, 32'hFFFF_0020, 32'h0,         4'h0, 32'h12BB56DD, 3};
        vecs[4] = '{0, 0, 32'h0001_0020, 32'h0,         4'h0, 32'h12BB56DD, 3};
        vecs[5] = '{1, 1, 32'h0000_0024, 32'hCAFEF00D, 4'hF, 32'h0,        3};
        vecs[6] = '{0, 0, 32'h0000_0024, 32'h0,         4'h0, 32'hCAFEF00D, 3};

        // reset state
        do_reset();
        check("reset_outputs",
              64'({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready, f_done, d_done}), 64'(0));
        check("reset_data", {f_data, d_rdata}, 64'(0));

        // both requests held: tie order after reset
        f_req = 1; f_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h44;
        for (int t = 0; t < 4; t++) begin
            dn = 2'b00;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (f_done || d_done) begin dn = {f_done, d_done}; break; end
            end
`ifdef ARB_DATA_PRIORITY_EN
            exp_dn = 2'b01;
`else
            exp_dn = (t % 2 == 0) ? 2'b01 : 2'b10;
`endif
            check($sformatf("tie_order_%0d", t), 64'(dn), 64'(exp_dn));
        end
        f_req = 0; d_req = 0;
        @(negedge clk);

        // write with awready one cycle ahead of wready
        cfg_aw_lat = 0; cfg_w_lat = 1;
        d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h12345678; d_strb = 4'hF;
        @(negedge clk);
        check("wr_c1_hs", 64'({bus.awvalid, bus.wvalid, bus.awready, bus.wready}), 64'(4'b1110));
        check("wr_c1_payload", {bus.awaddr, bus.wdata, 12'h0, bus.wstrb}, {16'h0020, 32'h12345678, 16'h000F});
        @(negedge clk);
        check("wr_c2_hs", 64'({bus.awvalid, bus.wvalid, bus.wready, bus.bready}), 64'(4'b0110));
        @(negedge clk);
        check("wr_c3_resp", 64'({bus.bready, bus.bvalid, d_done}), 64'(3'b110));
        @(negedge clk);
        check("wr_done", 64'({f_done, d_done}), 64'(2'b01));
        d_req = 0;
        @(negedge clk);
        check("wr_done_once", 64'({f_done, d_done}), 64'(0));
        ref_mem[8] = 32'h12345678;
        cfg_w_lat = 0;

        // directed vector table
        for (int v = 0; v < 7; v++) begin
            run_txn(vecs[v].is_d, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].strb, lat, dn, data);
            check($sformatf("vec%0d_latency", v), 64'(lat), 64'(vecs[v].exp_lat));
            check($sformatf("vec%0d_port", v), 64'(dn), vecs[v].is_d ? 64'(2'b01) : 64'(2'b10));
            if (!vecs[v].we) check($sformatf("vec%0d_data", v), 64'(data), 64'(vecs[v].exp_data));
            else ref_mem[vecs[v].addr[9:2]] = merge(ref_mem[vecs[v].addr[9:2]], vecs[v].wdata, vecs[v].strb);
            @(negedge clk);
        end

        // arready stalled 5 cycles
        cfg_ar_lat = 5;
        f_req = 1; f_addr = 32'h0000_0030;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("stall_c%0d", k), 64'({bus.arvalid, bus.araddr, f_done}), 64'({1'b1, 16'h0030, 1'b0}));
        end
        @(negedge clk);
        check("stall_rdata_phase", 64'({bus.arvalid, bus.rready, f_done}), 64'(3'b010));
        @(negedge clk);
        check("stall_done", 64'({f_done, f_data}), {31'h0, 1'b1, ref_mem[12]});
        f_req = 0;
        cfg_ar_lat = 0;
        @(negedge clk);

        // reset while in READ_DATA
        f_req = 1; f_addr = 32'h10;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_in_read_data", 64'(bus.rready), 64'(1));
        rst = 1; f_req = 0;
        @(negedge clk);
        check("rst_mid_quiet",
              64'({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready, f_done, d_done}), 64'(0));
        check("rst_mid_data", {f_data, d_rdata}, 64'(0));
        rst = 0;
        dn = 2'b00;
        repeat (3) begin
            @(negedge clk);
            dn = dn | {f_done, d_done};
        end
        check("rst_mid_no_done", 64'(dn), 64'(0));
        run_txn(0, 0, 32'h10, 32'h0, 4'h0, lat, dn, data);
        check("rst_after_fetch", {24'(lat), dn, data}, {24'd3, 2'b10, 32'hDEADBEEF});
        @(negedge clk);

        // Done pulse width; request presented during DONE waits for IDLE
        run_txn(0, 0, 32'h14, 32'h0, 4'h0, lat, dn, data);
        check("pulse_fetch", 64'({dn, data}), {30'h0, 2'b10, ref_mem[5]});
        d_req = 1; d_we = 0; d_addr = 32'h18;
        @(negedge clk);
        check("pulse_idle_gap", 64'({f_done, d_done, bus.arvalid, bus.awvalid}), 64'(0));
        @(negedge clk);
        check("pulse_then_grant", 64'({bus.arvalid, bus.araddr}), 64'({1'b1, 16'h0018}));
        dn = 2'b00;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (f_done || d_done) begin dn = {f_done, d_done}; break; end
        end
        check("pulse_d_result", {30'h0, dn, d_rdata}, {30'h0, 2'b01, ref_mem[6]});
        d_req = 0;

        // randomized run against the transaction-level model
        do_reset();
        rand_lat = 1;
        m_busy = 0; m_owner = 0; done_prev = 0;
`ifndef ARB_DATA_PRIORITY_EN
        m_last = 0;
`endif
        last_f = '0; last_d = '0; exp_f = '0; exp_d = '0;
        m_d_we = 0; m_d_addr = '0; m_d_wdata = '0; m_d_strb = '0;
        busy_cyc = 0; txn_done = 0;
        for (int cyc = 0; cyc < 4000 && txn_done < 200; cyc++) begin
            // the edge just taken: DONE->IDLE, or a grant out of IDLE
            if (m_busy) begin
                if (done_prev) m_busy = 0;
            end else if (f_req || d_req) begin
                if (f_req && d_req) begin
`ifdef ARB_DATA_PRIORITY_EN
                    win = 1;
`else
                    win = !m_last;
`endif
                end else begin
                    win = d_req;
                end
`ifndef ARB_DATA_PRIORITY_EN
                m_last = win;
`endif
                m_busy = 1; m_owner = win; busy_cyc = 0;
                if (win) begin
                    m_d_we = d_we; m_d_addr = d_addr; m_d_wdata = d_wdata; m_d_strb = d_strb;
                    if (!d_we) exp_d = ref_mem[d_addr[9:2]];
                end else begin
                    exp_f = ref_mem[f_addr[9:2]];
                end
            end
            @(negedge clk);
            if (m_busy) busy_cyc++;
            if (busy_cyc > 40) begin
                n_checks++; n_fail++;
                $display("FAIL rnd_timeout: no Done after %0d cycles, owner %0d", busy_cyc, m_owner);
                break;
            end
            done_prev = 0;
            if (f_done || d_done) begin
                exp_dn = !m_busy ? 2'b00 : (m_owner ? 2'b01 : 2'b10);
                check("rnd_done_owner", 64'({f_done, d_done}), 64'(exp_dn));
                done_prev = m_busy;
                if (m_busy && !m_owner) begin
                    last_f = exp_f;
                end else if (m_busy && m_owner) begin
                    if (m_d_we) ref_mem[m_d_addr[9:2]] = merge(ref_mem[m_d_addr[9:2]], m_d_wdata, m_d_strb);
                    else        last_d = exp_d;
                end
                check("rnd_data", {f_data, d_rdata}, {last_f, last_d});
                txn_done++;
            end
            if (f_done) f_req = 0;
            if (d_done) d_req = 0;
            if (!f_req && $urandom_range(0, 2) == 0) begin
                f_req  = 1;
                f_addr = ($urandom() & 32'hFFFF_0000) | (32'($urandom_range(0, 255)) << 2);
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req   = 1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = ($urandom() & 32'hFFFF_0000) | (32'($urandom_range(0, 255)) << 2);
                d_wdata = $urandom();
                d_strb  = 4'($urandom_range(1, 15));
            end
        end
        check("rnd_enough_txns", 64'(txn_done >= 50), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
